// File: rtl/iq_comp_ctrl.sv
// Purpose : mode/training controller for the IQ compensation datapath (IDLE/TRAIN/LOCK/EXT).
// Latency : all outputs registered; a state change is visible one cycle after the deciding edge.
// Backpr. : none; start is a one-cycle pulse, abort/ext_mode are levels sampled every cycle.
//
// Ports:
//   clk, RESET (sync, active-high)
//   start, abort, ext_mode          - control requests
//   delta_thresh, train_timeout     - stability threshold on |dW| and TRAIN cycle limit (0 = none)
//   Wr, Wj                          - live signed coefficients from the datapath
//   op_mode, freeze_iqcomp, busy    - datapath mode / W freeze / training in progress
//   settled, timeout                - how the last training ended
//   Wr_hold, Wj_hold                - W captured on the TRAIN->LOCK edge
module iq_comp_ctrl #(
    parameter int W_WIDTH    = 13,
    parameter int SETTLE_LEN = 64,
    parameter int TMR_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        RESET,
    input  logic                        start,
    input  logic                        abort,
    input  logic                        ext_mode,
    input  logic        [5:0]           delta_thresh,
    input  logic        [TMR_WIDTH-1:0] train_timeout,
    input  logic signed [W_WIDTH-1:0]   Wr,
    input  logic signed [W_WIDTH-1:0]   Wj,
    output logic        [1:0]           op_mode,
    output logic                        freeze_iqcomp,
    output logic                        busy,
    output logic                        settled,
    output logic                        timeout,
    output logic signed [W_WIDTH-1:0]   Wr_hold,
    output logic signed [W_WIDTH-1:0]   Wj_hold
);

    localparam int DW    = W_WIDTH + 1;
    localparam int CNT_W = $clog2(SETTLE_LEN + 1);

    typedef enum logic [1:0] {IDLE, TRAIN, LOCK, EXT} state_t;

    state_t                      state;
    logic                        first;      // first TRAIN cycle: load prev, no comparison
    logic        [CNT_W-1:0]     stable_cnt;
    logic        [TMR_WIDTH-1:0] timer;
    logic signed [W_WIDTH-1:0]   wr_prev;
    logic signed [W_WIDTH-1:0]   wj_prev;

    logic signed [DW-1:0]        dr;
    logic signed [DW-1:0]        dj;
    logic        [DW-1:0]        abs_dr;
    logic        [DW-1:0]        abs_dj;
    logic        [DW-1:0]        thresh_ext;
    logic                        stable;
    logic        [CNT_W-1:0]     cnt_next;
    logic        [TMR_WIDTH-1:0] timer_next;
    logic                        settle_hit;
    logic                        timer_hit;

    // {op_mode, freeze_iqcomp, busy} for the state being entered
    function automatic logic [3:0] outs(state_t s);
        case (s)
            TRAIN:   outs = {2'b01, 1'b0, 1'b1};
            LOCK:    outs = {2'b01, 1'b1, 1'b0};
            EXT:     outs = {2'b10, 1'b1, 1'b0};
            default: outs = {2'b00, 1'b1, 1'b0};
        endcase
    endfunction

    always_comb begin
        // one extra bit so the difference of two extreme values cannot overflow
        dr         = {Wr[W_WIDTH-1], Wr} - {wr_prev[W_WIDTH-1], wr_prev};
        dj         = {Wj[W_WIDTH-1], Wj} - {wj_prev[W_WIDTH-1], wj_prev};
        abs_dr     = dr[DW-1] ? $unsigned(-dr) : $unsigned(dr);
        abs_dj     = dj[DW-1] ? $unsigned(-dj) : $unsigned(dj);
        thresh_ext = DW'(delta_thresh);
        stable     = (abs_dr <= thresh_ext) && (abs_dj <= thresh_ext);
        cnt_next   = stable ? stable_cnt + CNT_W'(1) : '0;
        timer_next = (&timer) ? timer : timer + TMR_WIDTH'(1);
        settle_hit = !first && (cnt_next == CNT_W'(SETTLE_LEN));
        // timer_next counts this cycle, so a limit of N ends training after N TRAIN cycles
        timer_hit  = (train_timeout != '0) && (timer_next == train_timeout);
    end

    always_ff @(posedge clk) begin
        if (RESET) begin
            state                            <= IDLE;
            {op_mode, freeze_iqcomp, busy}   <= outs(IDLE);
            settled                          <= 1'b0;
            timeout                          <= 1'b0;
            Wr_hold                          <= '0;
            Wj_hold                          <= '0;
            first                            <= 1'b0;
            stable_cnt                       <= '0;
            timer                            <= '0;
            wr_prev                          <= '0;
            wj_prev                          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ext_mode) begin
                        state                          <= EXT;
                        {op_mode, freeze_iqcomp, busy} <= outs(EXT);
                        settled                        <= 1'b0;
                        timeout                        <= 1'b0;
                    end else if (start) begin
                        state                          <= TRAIN;
                        {op_mode, freeze_iqcomp, busy} <= outs(TRAIN);
                        settled                        <= 1'b0;
                        timeout                        <= 1'b0;
                        stable_cnt                     <= '0;
                        timer                          <= '0;
                        first                          <= 1'b1;
                    end
                end
                TRAIN: begin
                    if (abort) begin
                        state                          <= IDLE;
                        {op_mode, freeze_iqcomp, busy} <= outs(IDLE);
                        settled                        <= 1'b0;
                        timeout                        <= 1'b0;
                    end else begin
                        first      <= 1'b0;
                        timer      <= timer_next;
                        wr_prev    <= Wr;
                        wj_prev    <= Wj;
                        stable_cnt <= first ? '0 : cnt_next;
                        // settle wins a tie with the timer
                        if (settle_hit || timer_hit) begin
                            state                          <= LOCK;
                            {op_mode, freeze_iqcomp, busy} <= outs(LOCK);
                            settled                        <= settle_hit;
                            timeout                        <= !settle_hit;
                            Wr_hold                        <= Wr;
                            Wj_hold                        <= Wj;
                        end
                    end
                end
                LOCK: begin
                    if (abort) begin
                        state                          <= IDLE;
                        {op_mode, freeze_iqcomp, busy} <= outs(IDLE);
                        settled                        <= 1'b0;
                        timeout                        <= 1'b0;
                    end else if (ext_mode) begin
                        state                          <= EXT;
                        {op_mode, freeze_iqcomp, busy} <= outs(EXT);
                        settled                        <= 1'b0;
                        timeout                        <= 1'b0;
                    end else if (start) begin
                        state                          <= TRAIN;
                        {op_mode, freeze_iqcomp, busy} <= outs(TRAIN);
                        settled                        <= 1'b0;
                        timeout                        <= 1'b0;
                        stable_cnt                     <= '0;
                        timer                          <= '0;
                        first                          <= 1'b1;
                    end
                end
                EXT: begin
                    if (!ext_mode) begin
                        state                          <= IDLE;
                        {op_mode, freeze_iqcomp, busy} <= outs(IDLE);
                    end
                end
                default: begin
                    state                          <= IDLE;
                    {op_mode, freeze_iqcomp, busy} <= outs(IDLE);
                end
            endcase
        end
    end

endmodule
